stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo_pkg.sv | 19 +
 rtl/stream_fifo_mem.sv | 31 +++
 rtl/stream_fifo.sv | 164 ++++++++++++++++
 tb/tb_stream_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared constants and sizing helpers for the stream FIFO slice.
package stream_fifo_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 3;
  localparam int DEF_AEMPTY_THR = 1;
  localparam int DEF_FWFT       = 1;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; the control logic tracks validity.
module stream_fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = ptr_width(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the incoming word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO control: modulo-DEPTH pointers, registered occupancy count,
// count-decoded flags, sticky error flags and FWFT / registered read paths.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AFULL_THR  = DEPTH - 1,
  parameter int AEMPTY_THR = DEF_AEMPTY_THR,
  parameter int FWFT       = DEF_FWFT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         r_ready,
  output logic                         r_valid,
  output logic [WIDTH-1:0]             data_out,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_THR);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic          REG_READ   = (FWFT == 0) ? 1'b1 : 1'b0;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             pop_s;
  logic [WIDTH-1:0] rd_data_s;

  // Advance a pointer with explicit wrap at DEPTH-1 (DEPTH need not be 2^n).
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Decode status from the registered count and qualify write/pop requests.
  // A full FIFO never accepts a write even if a pop happens the same cycle.
  always_comb begin
    full_s  = (count_r == DEPTH_C);
    empty_s = (count_r == {CW{1'b0}});
    wr_en_s = w_valid && !full_s && !reset;
    pop_s   = r_ready && !empty_s && !reset;
  end

  // Pointer and occupancy update; a reset cycle discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags: dropped writes and empty read requests (registered mode).
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | (w_valid & full_s);
      underflow_r <= underflow_r | (REG_READ & r_ready & empty_s);
    end
  end

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      logic [WIDTH-1:0] data_out_s;

      // Head entry falls through; masked to zero while empty so reset reads 0.
      always_comb begin
        if (empty_s) begin
          data_out_s = {WIDTH{1'b0}};
        end else begin
          data_out_s = rd_data_s;
        end
      end

      assign r_valid  = !empty_s;
      assign data_out = data_out_s;
    end else begin : g_reg
      logic             r_valid_r;
      logic [WIDTH-1:0] data_out_r;

      // Registered read: popped word is presented for exactly one cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid_r  <= 1'b0;
          data_out_r <= {WIDTH{1'b0}};
        end else begin
          r_valid_r <= pop_s;
          if (pop_s) begin
            data_out_r <= rd_data_s;
          end else begin
            data_out_r <= data_out_r;
          end
        end
      end

      assign r_valid  = r_valid_r;
      assign data_out = data_out_r;
    end
  endgenerate

  assign w_ready      = !full_s;
  assign fifo_full    = full_s;
  assign fifo_empty   = empty_s;
  assign almost_full  = (count_r >= AFULL_C);
  assign almost_empty = (count_r <= AEMPTY_C);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop and compare.
module tb_stream_fifo;

  logic        clk;
  logic        reset;

  // FWFT instance (a) signals
  logic        w_valid_a, w_ready_a, r_ready_a, r_valid_a;
  logic [31:0] data_in_a, data_out_a;
  logic        full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
  logic [1:0]  count_a;

  // Registered-read instance (b) signals
  logic        w_valid_b, w_ready_b, r_ready_b, r_valid_b;
  logic [31:0] data_in_b, data_out_b;
  logic        full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
  logic [1:0]  count_b;

  int compared;
  int mismatched;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  stream_fifo #(.WIDTH(32), .DEPTH(3), .AFULL_THR(2), .AEMPTY_THR(1), .FWFT(1)) dut_a (
    .clk(clk), .reset(reset), .w_valid(w_valid_a), .w_ready(w_ready_a),
    .data_in(data_in_a), .r_ready(r_ready_a), .r_valid(r_valid_a),
    .data_out(data_out_a), .fifo_full(full_a), .fifo_empty(empty_a),
    .almost_full(afull_a), .almost_empty(aempty_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  stream_fifo #(.WIDTH(32), .DEPTH(3), .AFULL_THR(2), .AEMPTY_THR(1), .FWFT(0)) dut_b (
    .clk(clk), .reset(reset), .w_valid(w_valid_b), .w_ready(w_ready_b),
    .data_in(data_in_b), .r_ready(r_ready_b), .r_valid(r_valid_b),
    .data_out(data_out_b), .fifo_full(full_b), .fifo_empty(empty_b),
    .almost_full(afull_b), .almost_empty(aempty_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the FWFT instance: a transfer happens when r_valid && r_ready.
  always @(negedge clk) begin
    if (r_valid_a === 1'b1 && r_ready_a === 1'b1) begin
      if (qa.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL fwft_unexpected: got %h expected no word", data_out_a);
      end else begin
        chk("fwft_data", data_out_a, qa.pop_front());
      end
    end
  end

  // Monitor for the registered-read instance: every r_valid cycle carries a word.
  always @(negedge clk) begin
    if (r_valid_b === 1'b1) begin
      if (qb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL reg_unexpected: got %h expected no word", data_out_b);
      end else begin
        chk("reg_data", data_out_b, qb.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    w_valid_a = 1'b0; r_ready_a = 1'b0; data_in_a = 32'd0;
    w_valid_b = 1'b0; r_ready_b = 1'b0; data_in_b = 32'd0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_empty",  {31'd0, empty_a},  32'd1);
    chk("rst_aempty", {31'd0, aempty_a}, 32'd1);
    chk("rst_full",   {31'd0, full_a},   32'd0);
    chk("rst_afull",  {31'd0, afull_a},  32'd0);
    chk("rst_count",  {30'd0, count_a},  32'd0);
    chk("rst_rvalid", {31'd0, r_valid_a}, 32'd0);
    chk("rst_dout",   data_out_a,        32'd0);
    chk("rst_dout_b", data_out_b,        32'd0);
    chk("rst_rvalid_b", {31'd0, r_valid_b}, 32'd0);

    // Fill with 0,1,2
    w_valid_a = 1'b1; data_in_a = 32'd0; qa.push_back(32'd0);
    step();
    chk("fill1_count",  {30'd0, count_a},   32'd1);
    chk("fill1_rvalid", {31'd0, r_valid_a}, 32'd1);
    chk("fill1_dout",   data_out_a,         32'd0);
    chk("fill1_aempty", {31'd0, aempty_a},  32'd1);
    data_in_a = 32'd1; qa.push_back(32'd1);
    step();
    chk("fill2_count",  {30'd0, count_a},  32'd2);
    chk("fill2_afull",  {31'd0, afull_a},  32'd1);
    chk("fill2_aempty", {31'd0, aempty_a}, 32'd0);
    data_in_a = 32'd2; qa.push_back(32'd2);
    step();
    chk("fill3_count",  {30'd0, count_a},   32'd3);
    chk("fill3_full",   {31'd0, full_a},    32'd1);
    chk("fill3_wready", {31'd0, w_ready_a}, 32'd0);

    // Write while full is dropped
    data_in_a = 32'd3;
    step();
    chk("ovf_flag",  {31'd0, ovf_a},    32'd1);
    chk("ovf_count", {30'd0, count_a},  32'd3);
    w_valid_a = 1'b0;

    // Drain 0,1,2
    r_ready_a = 1'b1;
    step();
    step();
    step();
    chk("drain_empty", {31'd0, empty_a},  32'd1);
    chk("drain_count", {30'd0, count_a},  32'd0);
    step();
    chk("fwft_no_underflow", {31'd0, unf_a}, 32'd0);

    // Continuous write + read of 0..9
    for (int i = 0; i < 10; i++) begin
      w_valid_a = 1'b1;
      data_in_a = i;
      qa.push_back(i);
      step();
      chk("stream_count", {30'd0, count_a}, 32'd1);
    end
    w_valid_a = 1'b0;
    step();
    chk("stream_empty", {31'd0, empty_a}, 32'd1);

    // Reset mid-operation
    r_ready_a = 1'b0;
    w_valid_a = 1'b1; data_in_a = 32'h11;
    step();
    data_in_a = 32'h22;
    step();
    chk("pre_rst_count", {30'd0, count_a}, 32'd2);
    chk("pre_rst_ovf",   {31'd0, ovf_a},   32'd1);
    reset = 1'b1; data_in_a = 32'h99;
    step();
    reset = 1'b0; w_valid_a = 1'b0;
    chk("mid_rst_count",  {30'd0, count_a},   32'd0);
    chk("mid_rst_empty",  {31'd0, empty_a},   32'd1);
    chk("mid_rst_ovf",    {31'd0, ovf_a},     32'd0);
    chk("mid_rst_rvalid", {31'd0, r_valid_a}, 32'd0);
    w_valid_a = 1'b1; data_in_a = 32'h5A; qa.push_back(32'h5A);
    step();
    w_valid_a = 1'b0;
    chk("post_rst_dout",   data_out_a,         32'h5A);
    chk("post_rst_rvalid", {31'd0, r_valid_a}, 32'd1);
    r_ready_a = 1'b1;
    step();
    r_ready_a = 1'b0;
    chk("post_rst_empty", {31'd0, empty_a}, 32'd1);

    // Registered-read mode
    w_valid_b = 1'b1; data_in_b = 32'hA5; qb.push_back(32'hA5);
    step();
    w_valid_b = 1'b0;
    chk("reg_idle_rvalid", {31'd0, r_valid_b}, 32'd0);
    chk("reg_count1",      {30'd0, count_b},   32'd1);
    r_ready_b = 1'b1;
    step();
    r_ready_b = 1'b0;
    chk("reg_rvalid",   {31'd0, r_valid_b}, 32'd1);
    chk("reg_dout",     data_out_b,         32'hA5);
    chk("reg_count0",   {30'd0, count_b},   32'd0);
    step();
    chk("reg_rvalid_drop", {31'd0, r_valid_b}, 32'd0);
    chk("reg_dout_hold",   data_out_b,         32'hA5);
    chk("reg_no_unf",      {31'd0, unf_b},     32'd0);
    r_ready_b = 1'b1;
    step();
    r_ready_b = 1'b0;
    chk("reg_unf",        {31'd0, unf_b},     32'd1);
    chk("reg_unf_rvalid", {31'd0, r_valid_b}, 32'd0);
    step();
    chk("reg_unf_sticky", {31'd0, unf_b},     32'd1);

    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
